exponent_accel_core: RTL and testbench



---
 rtl/exponent_accel_core.sv | 123 ++++++++++++
 tb/tb_exponent_accel_core.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/exponent_accel_core.sv
// Avalon-MM integer power engine: RESULT = BASE^EXP mod 2^32 by square-and-multiply,
// one exponent bit per cycle, with a sticky flag for results wider than 32 bits.
module exponent_accel_core #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        address,
  input  logic              read,
  input  logic              write,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata,
  output logic              irq
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state;
  logic [DATA_W-1:0]   base_reg;
  logic [DATA_W-1:0]   exp_reg;
  logic [DATA_W-1:0]   result_reg;
  logic [DATA_W-1:0]   cycles_reg;
  logic [DATA_W-1:0]   acc;
  logic [DATA_W-1:0]   b;
  logic [DATA_W-1:0]   e;
  logic                done;
  logic                overflow;
  logic                irq_en;

  logic [2*DATA_W-1:0] acc_prod;
  logic [2*DATA_W-1:0] sq_prod;
  logic                busy;
  logic                ctrl_write;
  logic                start;
  logic                e_more;
  logic [DATA_W-1:0]   status;

  // Both multiplies are evaluated every RUN cycle; the FSM picks what to keep.
  assign acc_prod   = {{DATA_W{1'b0}}, acc} * {{DATA_W{1'b0}}, b};
  assign sq_prod    = {{DATA_W{1'b0}}, b} * {{DATA_W{1'b0}}, b};
  assign busy       = (state != IDLE);
  assign ctrl_write = write && (address == 3'd2);
  assign start      = ctrl_write && writedata[0];
  assign e_more     = (e >> 1) != '0;
  assign status     = {{(DATA_W-4){1'b0}}, overflow, irq_en, done, busy};
  assign irq        = done & irq_en;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      base_reg   <= '0;
      exp_reg    <= '0;
      result_reg <= '0;
      cycles_reg <= '0;
      acc        <= {{(DATA_W-1){1'b0}}, 1'b1};
      b          <= '0;
      e          <= '0;
      done       <= 1'b0;
      overflow   <= 1'b0;
      irq_en     <= 1'b0;
      readdata   <= '0;
    end else begin
      if (write && address == 3'd0) base_reg <= writedata;
      if (write && address == 3'd1) exp_reg  <= writedata;
      if (ctrl_write) begin
        irq_en <= writedata[2];
        if (writedata[1]) done <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (start) begin
            acc        <= {{(DATA_W-1){1'b0}}, 1'b1};
            b          <= base_reg;
            e          <= exp_reg;
            done       <= 1'b0;
            overflow   <= 1'b0;
            cycles_reg <= '0;
            state      <= RUN;
          end
        end
        RUN: begin
          cycles_reg <= cycles_reg + 1'b1;
          if (e == '0) begin
            state <= DONE;
          end else begin
            if (e[0]) begin
              acc <= acc_prod[DATA_W-1:0];
              if (acc_prod[2*DATA_W-1:DATA_W] != '0) overflow <= 1'b1;
            end
            // A squared base that will never be used again cannot overflow the result.
            b <= sq_prod[DATA_W-1:0];
            if (sq_prod[2*DATA_W-1:DATA_W] != '0 && e_more) overflow <= 1'b1;
            e <= e >> 1;
          end
        end
        DONE: begin
          cycles_reg <= cycles_reg + 1'b1;
          result_reg <= acc;
          done       <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (read) begin
        case (address)
          3'd0:    readdata <= base_reg;
          3'd1:    readdata <= exp_reg;
          3'd2:    readdata <= status;
          3'd3:    readdata <= result_reg;
          3'd4:    readdata <= cycles_reg;
          default: readdata <= '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_exponent_accel_core.sv
// Randomized and directed bench for exponent_accel_core against a saturating
// repeated-multiplication reference model.
module tb_exponent_accel_core;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        irq;

  int checks = 0;
  int errors = 0;
  logic irq_at;

  exponent_accel_core #(.DATA_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .read(read), .write(write),
    .writedata(writedata), .readdata(readdata), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
    end
  endtask

  // Inputs change on the falling edge; the DUT captures them on the next rising edge.
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; write = 1'b1;
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    irq_at = irq;
    address = a; read = 1'b1;
    @(negedge clk);
    read = 1'b0;
    d = readdata;
  endtask

  // True power, tracked exactly mod 2^32 and saturated at 2^32 to decide overflow.
  function automatic void model(input logic [31:0] bs, input logic [31:0] ex,
                                output logic [31:0] r, output bit ov, output int cyc);
    logic [63:0] sat;
    logic [31:0] res;
    sat = 64'd1;
    res = 32'd1;
    for (longint i = 0; i < longint'(ex); i++) begin
      res = res * bs;
      sat = sat * {32'd0, bs};
      if (sat > 64'hFFFF_FFFF) sat = 64'h1_0000_0000;
      if (bs <= 32'd1 || (res == 32'd0 && (sat == 64'd0 || sat > 64'hFFFF_FFFF))) break;
    end
    r   = res;
    ov  = sat > 64'hFFFF_FFFF;
    cyc = 2;
    for (int k = 0; k < 32; k++) if (ex[k]) cyc = k + 3;
  endfunction

  task automatic start_op(input logic [31:0] bs, input logic [31:0] ex, input bit en);
    wr(3'd0, bs);
    wr(3'd1, ex);
    wr(3'd2, {29'd0, en, 1'b0, 1'b1});
  endtask

  // prior = busy cycles already consumed by other bus traffic since the start write.
  task automatic finish_op(input logic [31:0] bs, input logic [31:0] ex, input bit en,
                           input int prior);
    logic [31:0] r, d;
    bit ov, irq_busy, timed_out;
    int cyc, nbusy;
    model(bs, ex, r, ov, cyc);
    nbusy = 0; irq_busy = 0; timed_out = 1;
    for (int i = 0; i < 200; i++) begin
      rd(3'd2, d);
      if (!d[0]) begin timed_out = 0; break; end
      nbusy++;
      if (irq_at) irq_busy = 1;
    end
    check("timeout", {31'd0, timed_out}, 32'd0);
    check("busy_cycles", nbusy, cyc - prior);
    check("irq_while_busy", {31'd0, irq_busy}, 32'd0);
    check("irq_after_done", {31'd0, irq_at}, {31'd0, en});
    check("status", d, {28'd0, ov, en, 1'b1, 1'b0});
    rd(3'd3, d);
    check("result", d, r);
    rd(3'd4, d);
    check("cycles", d, cyc);
    $display("op base=0x%08h exp=0x%08h result=0x%08h ovf=%0d cycles=%0d", bs, ex, d, ov, cyc);
  endtask

  task automatic do_op(input logic [31:0] bs, input logic [31:0] ex, input bit en);
    start_op(bs, ex, en);
    finish_op(bs, ex, en, 0);
  endtask

  initial begin
    logic [31:0] d, bs, ex;
    repeat (3) @(negedge clk);
    check("reset_readdata", readdata, 32'd0);
    check("reset_irq", {31'd0, irq}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    for (int a = 0; a < 8; a++) begin
      rd(3'(a), d);
      check($sformatf("reset_reg%0d", a), d, 32'd0);
    end

    do_op(32'd3, 32'd5, 1'b0);
    do_op(32'd2, 32'd31, 1'b0);
    do_op(32'd2, 32'd32, 1'b0);
    do_op(32'd0, 32'd0, 1'b0);
    do_op(32'd7, 32'd0, 1'b0);
    do_op(32'd0, 32'd9, 1'b0);

    // Second start and a BASE write while busy leave the running 3^5 intact.
    start_op(32'd3, 32'd5, 1'b0);
    wr(3'd0, 32'd99);
    wr(3'd2, 32'd1);
    finish_op(32'd3, 32'd5, 1'b0, 2);
    rd(3'd0, d);
    check("base_after_busy_write", d, 32'd99);
    rd(3'd1, d);
    check("exp_after_busy_write", d, 32'd5);

    // Reserved addresses ignore writes and read zero; readdata holds without read.
    wr(3'd5, 32'hDEAD_BEEF);
    rd(3'd5, d);
    check("reserved_read", d, 32'd0);
    rd(3'd0, d);
    repeat (3) @(negedge clk);
    check("readdata_hold", readdata, 32'd99);

    // Interrupt enabled, then cleared by the write-1-to-clear done bit.
    do_op(32'd5, 32'd3, 1'b1);
    wr(3'd2, 32'b110);
    check("irq_cleared", {31'd0, irq}, 32'd0);
    rd(3'd2, d);
    check("status_cleared", d, 32'b0100);

    // Reset mid-RUN aborts without writing a partial result.
    do_op(32'd3, 32'd5, 1'b1);
    start_op(32'd3, 32'd5, 1'b1);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("abort_irq", {31'd0, irq}, 32'd0);
    check("abort_readdata", readdata, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    rd(3'd2, d);
    check("abort_status", d, 32'd0);
    rd(3'd3, d);
    check("abort_result", d, 32'd0);
    rd(3'd4, d);
    check("abort_cycles", d, 32'd0);
    do_op(32'd3, 32'd5, 1'b0);

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0: begin bs = $urandom;                 ex = $urandom_range(0, 40);  end
        1: begin bs = $urandom_range(0, 20);    ex = $urandom_range(0, 300); end
        2: begin bs = $urandom & 32'hFFFF_FFFE; ex = $urandom;               end
        default: begin bs = {31'd0, 1'($urandom)}; ex = $urandom;            end
      endcase
      do_op(bs, ex, 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
